// File: rtl/word_pack_pkg.sv
// -----------------------------------------------------------------------------
// word_pack_pkg
// Shared definitions for the word packer: the packer FSM state type and
// elaboration-time helpers that derive beat geometry from the widths.
//   calc_beats  : number of input beats per packed word
//   calc_bpb    : byte-enable bits contributed by one beat
//   calc_cnt_w  : width of a beat counter that can hold 0..BEATS
//   calc_timer_w: width of a counter that can hold 0..limit (min 1 bit)
// -----------------------------------------------------------------------------
package word_pack_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_HOLD = 2'd1,
        ST_EMIT = 2'd2
    } pack_state_e;

    function automatic int calc_beats(input int data_w, input int word_w);
        return word_w / data_w;
    endfunction

    function automatic int calc_bpb(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int calc_cnt_w(input int beats);
        return $clog2(beats) + 1;
    endfunction

    function automatic int calc_timer_w(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/word_packer_v2_idle_timer.sv
// -----------------------------------------------------------------------------
// idle_timer
// Saturating idle-cycle counter with a terminal-count pulse.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : return the count to zero (wins over i_advance)
//   i_advance      : count one idle cycle
//   o_tc           : high in the cycle whose advance reaches LIMIT
// A LIMIT of 0 disables the timer entirely (o_tc never fires).
// -----------------------------------------------------------------------------
module idle_timer
    import word_pack_pkg::*;
#(
    parameter int LIMIT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_tc
);

    localparam int            TW    = calc_timer_w(LIMIT);
    localparam logic [TW-1:0] LIM_C = TW'(LIMIT);
    localparam logic [TW-1:0] ONE_C = TW'(1);

    logic [TW-1:0] r_count;
    logic          w_tc;

    // Terminal count is the advance that would take the count onto LIMIT.
    always_comb begin
        w_tc = 1'b0;
        if (LIMIT == 0) begin
            w_tc = 1'b0;
        end else begin
            w_tc = i_advance && !i_clear && (r_count == (LIM_C - ONE_C));
        end
    end

    // Idle counter: cleared on activity, saturates at LIMIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_advance && (LIMIT != 0) && (r_count != LIM_C)) begin
            r_count <= r_count + ONE_C;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = w_tc;

endmodule

// File: rtl/word_packer_v2.sv
// -----------------------------------------------------------------------------
// word_packer_v2
// Pops DATA_WIDTH beats from a show-ahead FIFO and packs them LSB-first into
// WORD_WIDTH words. Partial words are emitted on flush or idle timeout.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_data_in          : source FIFO head (valid when i_check_empty=0)
//   i_check_empty      : source FIFO empty
//   i_word_fifo_full   : destination FIFO full (back-pressure)
//   i_flush            : request to emit the current partial word
//   o_read_enable      : pop strobe to the source FIFO
//   o_data_out         : packed word, held while o_packed_done=1
//   o_byte_en          : valid-byte mask for o_data_out
//   o_packed_done      : one-cycle write strobe to the word FIFO
//   o_beat_count       : beats held in the current word
//   o_words_packed     : words emitted (wraps)
// -----------------------------------------------------------------------------
module word_packer_v2
    import word_pack_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int WORD_WIDTH   = 256,
    parameter int IDLE_TIMEOUT = 64,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [DATA_WIDTH-1:0]                  i_data_in,
    input  logic                                   i_check_empty,
    input  logic                                   i_word_fifo_full,
    input  logic                                   i_flush,
    output logic                                   o_read_enable,
    output logic [WORD_WIDTH-1:0]                  o_data_out,
    output logic [WORD_WIDTH/8-1:0]                o_byte_en,
    output logic                                   o_packed_done,
    output logic [$clog2(WORD_WIDTH/DATA_WIDTH):0] o_beat_count,
    output logic [CNT_WIDTH-1:0]                   o_words_packed
);

    localparam int             BEATS   = calc_beats(DATA_WIDTH, WORD_WIDTH);
    localparam int             BPB     = calc_bpb(DATA_WIDTH);
    localparam int             BCW     = calc_cnt_w(BEATS);
    localparam logic [BCW-1:0] BEATS_C = BCW'(BEATS);
    localparam logic [BCW-1:0] ONE_C   = BCW'(1);

    generate
        if (((WORD_WIDTH % DATA_WIDTH) != 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_params
            $fatal(1, "word_packer_v2: WORD_WIDTH must be a multiple of DATA_WIDTH, DATA_WIDTH a multiple of 8");
        end
    endgenerate

    pack_state_e             r_state;
    logic [WORD_WIDTH-1:0]   r_data;
    logic [WORD_WIDTH/8-1:0] r_be;
    logic [BCW-1:0]          r_beat_count;
    logic [CNT_WIDTH-1:0]    r_words;

    logic w_pop;
    logic w_advance;
    logic w_clear;
    logic w_tc;

    assign w_pop     = (r_state == ST_FILL) && !i_check_empty && !i_word_fifo_full
                       && (r_beat_count < BEATS_C);
    // A full word FIFO freezes the idle count as well as the pops.
    assign w_advance = (r_state == ST_FILL) && !w_pop && (r_beat_count != '0)
                       && !i_word_fifo_full;
    assign w_clear   = (r_state != ST_FILL) || w_pop;

    idle_timer #(
        .LIMIT (IDLE_TIMEOUT)
    ) u_idle_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_tc      (w_tc)
    );

    // Packer FSM and datapath: fill slots LSB-first, hold until the word FIFO
    // has room, then clear for the next word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_FILL;
            r_data       <= '0;
            r_be         <= '0;
            r_beat_count <= '0;
            r_words      <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_pop) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (r_beat_count == BCW'(k)) begin
                                r_data[k*DATA_WIDTH +: DATA_WIDTH] <= i_data_in;
                                r_be[k*BPB +: BPB]                 <= {BPB{1'b1}};
                            end
                        end
                        r_beat_count <= r_beat_count + ONE_C;
                        if (r_beat_count == (BEATS_C - ONE_C)) begin
                            r_state <= ST_HOLD;
                        end
                    end else if ((r_beat_count != '0) && (i_flush || w_tc)) begin
                        // A pop in the same cycle takes priority over flush.
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!i_word_fifo_full) begin
                        r_words <= r_words + CNT_WIDTH'(1);
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    r_data       <= '0;
                    r_be         <= '0;
                    r_beat_count <= '0;
                    r_state      <= ST_FILL;
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign o_read_enable  = w_pop;
    // Gated by the live full flag so a write is never offered to a full FIFO.
    assign o_packed_done  = (r_state == ST_HOLD) && !i_word_fifo_full;
    assign o_data_out     = r_data;
    assign o_byte_en      = r_be;
    assign o_beat_count   = r_beat_count;
    assign o_words_packed = r_words;

endmodule

// File: tb/tb_word_packer_v2.sv
module tb_word_packer_v2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: 8-bit beats into 256-bit words, idle timeout 8
    logic [7:0]   a_din;
    logic         a_empty, a_full, a_flush, a_rd, a_pd;
    logic [255:0] a_dout;
    logic [31:0]  a_be;
    logic [5:0]   a_bc;
    logic [15:0]  a_wp;

    // Instance B: 32-bit beats into 128-bit words, auto-flush disabled, 3-bit counter
    logic [31:0]  b_din;
    logic         b_empty, b_full, b_flush, b_rd, b_pd;
    logic [127:0] b_dout;
    logic [15:0]  b_be;
    logic [2:0]   b_bc;
    logic [2:0]   b_wp;

    word_packer_v2 #(.DATA_WIDTH(8), .WORD_WIDTH(256), .IDLE_TIMEOUT(8), .CNT_WIDTH(16)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_in(a_din), .i_check_empty(a_empty),
        .i_word_fifo_full(a_full), .i_flush(a_flush), .o_read_enable(a_rd),
        .o_data_out(a_dout), .o_byte_en(a_be), .o_packed_done(a_pd),
        .o_beat_count(a_bc), .o_words_packed(a_wp));

    word_packer_v2 #(.DATA_WIDTH(32), .WORD_WIDTH(128), .IDLE_TIMEOUT(0), .CNT_WIDTH(3)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_in(b_din), .i_check_empty(b_empty),
        .i_word_fifo_full(b_full), .i_flush(b_flush), .o_read_enable(b_rd),
        .o_data_out(b_dout), .o_byte_en(b_be), .o_packed_done(b_pd),
        .o_beat_count(b_bc), .o_words_packed(b_wp));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: source FIFOs, beats accepted since last emit, word counts
    logic [7:0]  a_q[$];
    logic [7:0]  a_acc[$];
    logic [31:0] b_q[$];
    logic [31:0] b_acc[$];
    int a_words = 0, b_words = 0;
    int a_pd_cnt = 0, b_pd_cnt = 0;
    int a_pd_cyc = 0, a_pop_cyc = 0;
    logic [255:0] a_pd_dout;
    logic [31:0]  a_pd_be;
    logic [127:0] b_pd_dout;
    logic [15:0]  b_pd_be;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pack_a();
        logic [255:0] w = '0;
        foreach (a_acc[i]) w = w | (256'(a_acc[i]) << (8 * i));
        return w;
    endfunction

    function automatic logic [255:0] pack_b();
        logic [255:0] w = '0;
        foreach (b_acc[i]) w = w | (256'(b_acc[i]) << (32 * i));
        return w;
    endfunction

    function automatic logic [255:0] mask_bits(input int nbits);
        return (256'(1) << nbits) - 256'(1);
    endfunction

    task automatic drive_src();
        a_empty = (a_q.size() == 0);
        a_din   = (a_q.size() != 0) ? a_q[0] : 8'h00;
        b_empty = (b_q.size() == 0);
        b_din   = (b_q.size() != 0) ? b_q[0] : 32'h0;
    endtask

    // One clock cycle starting at a negedge: sample, score, then model the pops.
    task automatic tick();
        logic ard, brd;
        #1;
        ard = a_rd;
        brd = b_rd;
        if (a_pd === 1'b1) begin
            chk("a_word", a_dout, pack_a());
            chk("a_byte_en", 256'(a_be), mask_bits(a_acc.size()));
            chk("a_words_packed", 256'(a_wp), 256'(a_words % 65536));
            a_words++;
            a_pd_cnt++;
            a_pd_cyc  = cyc;
            a_pd_dout = a_dout;
            a_pd_be   = a_be;
            a_acc.delete();
        end
        if (b_pd === 1'b1) begin
            chk("b_word", 256'(b_dout), pack_b());
            chk("b_byte_en", 256'(b_be), mask_bits(4 * b_acc.size()));
            chk("b_words_packed", 256'(b_wp), 256'(b_words % 8));
            b_words++;
            b_pd_cnt++;
            b_pd_dout = b_dout;
            b_pd_be   = b_be;
            b_acc.delete();
        end
        @(posedge clk);
        if (ard === 1'b1 && a_q.size() != 0) begin
            a_acc.push_back(a_q.pop_front());
            a_pop_cyc = cyc;
        end
        if (brd === 1'b1 && b_q.size() != 0) b_acc.push_back(b_q.pop_front());
        cyc++;
        @(negedge clk);
        drive_src();
    endtask

    task automatic run_a_pd(input int budget, input string tag);
        int start = a_pd_cnt;
        int n = 0;
        while (a_pd_cnt == start && n < budget) begin tick(); n++; end
        chk(tag, 256'(a_pd_cnt - start), 256'(1));
    endtask

    task automatic run_b_pd(input int budget, input string tag);
        int start = b_pd_cnt;
        int n = 0;
        while (b_pd_cnt == start && n < budget) begin tick(); n++; end
        chk(tag, 256'(b_pd_cnt - start), 256'(1));
    endtask

    task automatic run_a_acc(input int size, input int budget, input string tag);
        int n = 0;
        while (a_acc.size() < size && n < budget) begin tick(); n++; end
        chk(tag, 256'(a_acc.size()), 256'(size));
    endtask

    initial begin
        int pd0;
        rst_n = 1'b0;
        a_full = 1'b0; a_flush = 1'b0; b_full = 1'b0; b_flush = 1'b0;
        drive_src();
        repeat (3) @(negedge clk);
        chk("rst_a_dout", a_dout, 256'h0);
        chk("rst_a_be", 256'(a_be), 256'h0);
        chk("rst_a_pd", 256'(a_pd), 256'h0);
        chk("rst_a_bc", 256'(a_bc), 256'h0);
        chk("rst_a_wp", 256'(a_wp), 256'h0);
        chk("rst_b_dout", 256'(b_dout), 256'h0);
        rst_n = 1'b1;
        tick();

        // Full word: 0x00..0x1F back to back
        for (int i = 0; i < 32; i++) a_q.push_back(8'(i));
        drive_src();
        run_a_pd(60, "full_pd_timeout");
        chk("full_latency", 256'(a_pd_cyc - a_pop_cyc), 256'd1);
        chk("full_lsb", 256'(a_pd_dout[7:0]), 256'h00);
        chk("full_msb", 256'(a_pd_dout[255:248]), 256'h1F);
        chk("full_be", 256'(a_pd_be), 256'hFFFF_FFFF);
        repeat (5) tick();
        chk("full_single_pd", 256'(a_pd_cnt), 256'd1);
        chk("full_wp", 256'(a_wp), 256'd1);
        chk("full_bc_clear", 256'(a_bc), 256'd0);

        // Back-pressure in FILL: full after 31 beats
        for (int i = 0; i < 32; i++) a_q.push_back(8'($urandom));
        drive_src();
        run_a_acc(31, 60, "bp_fill31");
        a_full = 1'b1;
        pd0 = a_pd_cnt;
        repeat (10) tick();
        chk("bp_no_pop", 256'(a_acc.size()), 256'd31);
        chk("bp_no_pd", 256'(a_pd_cnt - pd0), 256'd0);
        a_full = 1'b0;
        run_a_pd(10, "bp_pd_timeout");
        chk("bp_latency", 256'(a_pd_cyc - a_pop_cyc), 256'd1);
        chk("bp_src_drained", 256'(a_q.size()), 256'd0);

        // Back-pressure in HOLD: full raised right after the last pop
        for (int i = 0; i < 32; i++) a_q.push_back(8'($urandom));
        drive_src();
        run_a_acc(32, 60, "hold_fill32");
        a_full = 1'b1;
        pd0 = a_pd_cnt;
        repeat (5) tick();
        chk("hold_no_pd", 256'(a_pd_cnt - pd0), 256'd0);
        a_full = 1'b0;
        run_a_pd(5, "hold_pd_timeout");

        // Manual flush of 5 bytes
        repeat (2) tick();
        for (int i = 0; i < 5; i++) a_q.push_back(8'(8'hA1 + i));
        drive_src();
        run_a_acc(5, 20, "flush_fill5");
        chk("flush_bc5", 256'(a_bc), 256'd5);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        run_a_pd(5, "flush_pd_timeout");
        chk("flush_low", 256'(a_pd_dout[39:0]), 256'hA5A4A3A2A1);
        chk("flush_high", 256'(a_pd_dout[255:40]), 256'h0);
        chk("flush_be", 256'(a_pd_be), 256'h1F);
        tick();
        chk("flush_bc0", 256'(a_bc), 256'd0);

        // Flush held high while popping: pops win, then flush closes the word
        a_q.push_back(8'h5A); a_q.push_back(8'hC3);
        drive_src();
        a_flush = 1'b1;
        run_a_pd(10, "popflush_pd_timeout");
        a_flush = 1'b0;
        chk("popflush_be", 256'(a_pd_be), 256'h3);

        // Idle timeout after 3 bytes
        tick();
        for (int i = 0; i < 3; i++) a_q.push_back(8'($urandom));
        drive_src();
        run_a_pd(30, "idle_pd_timeout");
        chk("idle_latency", 256'(a_pd_cyc - a_pop_cyc), 256'd9);
        chk("idle_be", 256'(a_pd_be), 256'h7);

        // Flush with zero beats is ignored
        tick();
        pd0 = a_pd_cnt;
        a_flush = 1'b1;
        repeat (12) tick();
        a_flush = 1'b0;
        chk("zero_flush_no_pd", 256'(a_pd_cnt - pd0), 256'd0);

        // Asynchronous reset mid-word
        for (int i = 0; i < 32; i++) a_q.push_back(8'($urandom));
        drive_src();
        run_a_acc(7, 20, "rst_fill7");
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_dout", a_dout, 256'h0);
        chk("midrst_be", 256'(a_be), 256'h0);
        chk("midrst_bc", 256'(a_bc), 256'h0);
        chk("midrst_wp", 256'(a_wp), 256'h0);
        chk("midrst_pd", 256'(a_pd), 256'h0);
        a_q.delete(); a_acc.delete(); a_words = 0;
        b_q.delete(); b_acc.delete(); b_words = 0;
        @(negedge clk);
        drive_src();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) a_q.push_back(8'($urandom));
        drive_src();
        pd0 = a_pd_cnt;
        run_a_pd(60, "postrst_pd_timeout");
        tick();
        chk("postrst_wp", 256'(a_wp), 256'd1);

        // Instance B: 32-bit beats
        for (int i = 1; i <= 4; i++) b_q.push_back({4{8'(8'h11 * i)}});
        drive_src();
        run_b_pd(20, "b_pd_timeout");
        chk("b_word_const", 256'(b_pd_dout), 256'h44444444_33333333_22222222_11111111);
        chk("b_be_const", 256'(b_pd_be), 256'hFFFF);

        // Auto-flush disabled: partial word waits for flush
        b_q.push_back(32'($urandom)); b_q.push_back(32'($urandom));
        drive_src();
        pd0 = b_pd_cnt;
        repeat (40) tick();
        chk("b_no_autoflush", 256'(b_pd_cnt - pd0), 256'd0);
        chk("b_bc2", 256'(b_bc), 256'd2);
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        run_b_pd(5, "b_flush_timeout");
        chk("b_flush_be", 256'(b_pd_be), 256'h00FF);

        // Counter wrap: 6 more words makes 8 on a 3-bit counter
        for (int i = 0; i < 24; i++) b_q.push_back(32'($urandom));
        drive_src();
        for (int w = 0; w < 6; w++) run_b_pd(20, "b_wrap_timeout");
        chk("b_wrap", 256'(b_wp), 256'(b_words % 8));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
